// File: rtl/reflet_ram_wide_pkg.sv
// rtl/reflet_ram_wide_pkg.sv - shared types, constants and parameter checks for the wide RAM
package reflet_ram_wide_pkg;

  // Controller phase: sequential clear after reset, then normal accesses
  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_RUN   = 1'b1
  } ram_state_e;

  localparam int BYTE_W = 8;

  // Word width must split evenly into byte lanes
  function automatic bit word_size_ok(input int w);
    return (w >= BYTE_W) && ((w % BYTE_W) == 0);
  endfunction

endpackage

// File: rtl/reflet_ram_clear_ctrl.sv
// rtl/reflet_ram_clear_ctrl.sv - clear-phase sequencer: state, clear counter and ready flag
module reflet_ram_clear_ctrl
  import reflet_ram_wide_pkg::*;
#(
  parameter int addrSize  = 8,
  parameter int size      = 256,
  parameter int resetable = 1
) (
  input  logic                clk,
  input  logic                reset,
  output logic                o_clr_we,
  output logic [addrSize-1:0] o_clr_addr,
  output logic                o_ready
);

  localparam logic [addrSize-1:0] LAST_ADDR = addrSize'(size - 1);

  ram_state_e          r_state;
  ram_state_e          w_state_nxt;
  logic [addrSize-1:0] r_clr_cnt;
  logic [addrSize-1:0] w_clr_cnt_nxt;
  logic                r_ready;

  // State, counter and ready registers; ready follows the state being entered
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= (resetable != 0) ? RAM_CLEAR : RAM_RUN;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_ready   <= (w_state_nxt == RAM_RUN);
    end
  end

  // Walk one word per cycle through the array, then hand over to RUN
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    o_clr_we      = 1'b0;
    case (r_state)
      RAM_CLEAR: begin
        o_clr_we = reset;
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt = RAM_RUN;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      RAM_RUN: begin
        w_state_nxt = RAM_RUN;
      end
      default: begin
        w_state_nxt = RAM_CLEAR;
      end
    endcase
  end

  assign o_clr_addr = r_clr_cnt;
  assign o_ready    = r_ready;

endmodule

// File: rtl/reflet_ram_wide.sv
// rtl/reflet_ram_wide.sv - single-port RAM with byte enables, sequential clear, valid and range flags
module reflet_ram_wide
  import reflet_ram_wide_pkg::*;
#(
  parameter int                   wordSize  = 16,
  parameter int                   addrSize  = 8,
  parameter int                   size      = 256,
  parameter int                   resetable = 1,
  parameter logic [wordSize-1:0]  clearVal  = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_enable,
  input  logic [addrSize-1:0]      i_addr,
  input  logic [wordSize-1:0]      i_data_in,
  input  logic                     i_write_en,
  input  logic [wordSize/8-1:0]    i_byte_en,
  output logic [wordSize-1:0]      o_data_out,
  output logic                     o_data_valid,
  output logic                     o_ready,
  output logic                     o_addr_err
);

  localparam int LANES = wordSize / BYTE_W;

  if (!word_size_ok(wordSize)) begin : g_bad_word_size
    $error("reflet_ram_wide: wordSize must be a multiple of 8 and at least 8");
  end
  if ((size < 1) || (size > (1 << addrSize))) begin : g_bad_size
    $error("reflet_ram_wide: size must be between 1 and 2**addrSize");
  end

  logic [wordSize-1:0] r_mem [size];
  logic [wordSize-1:0] r_data_out;
  logic                r_data_valid;
  logic                r_addr_err;

  logic                w_clr_we;
  logic [addrSize-1:0] w_clr_addr;
  logic                w_ready;
  logic                w_in_range;
  logic                w_access;
  logic                w_err_req;

  reflet_ram_clear_ctrl #(
    .addrSize  (addrSize),
    .size      (size),
    .resetable (resetable)
  ) u_clear_ctrl (
    .clk        (clk),
    .reset      (reset),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_ready    (w_ready)
  );

  // Requests are only honoured once clear is done and never while reset is held
  assign w_in_range = (32'(i_addr) < 32'(size));
  assign w_access   = reset & i_enable & w_ready & w_in_range;
  assign w_err_req  = reset & i_enable & w_ready & ~w_in_range;

  // Write port: clear sequencer has priority, otherwise user write through the byte lanes
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= clearVal;
    end else if (w_access && i_write_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (i_byte_en[i]) begin
          r_mem[i_addr][i*BYTE_W +: BYTE_W] <= i_data_in[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read-first output register with valid and out-of-range pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_data_out   <= w_access ? r_mem[i_addr] : '0;
      r_data_valid <= w_access;
      r_addr_err   <= w_err_req;
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_ready      = w_ready;
  assign o_addr_err   = r_addr_err;

endmodule
